// File: rtl/regs_bus_arbiter.sv
// Register-file port arbiter: SPI decoder (A) always wins,
// local requester (B) is issued in free slots with a deferral timeout.
module regs_bus_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MAX_DEFER = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_busy,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_timeout,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);

    localparam int CW = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_DEFER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_ISSUE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_b_we;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_wdata;
    logic              r_b_busy;
    logic              r_b_ack;
    logic              r_b_timeout;
    logic [DATA_W-1:0] r_b_rdata;

    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_write;
    logic              r_a_rd;
    logic [DATA_W-1:0] r_a_rdata;

    logic              w_a_pulse;
    logic              w_b_issue;
    logic [CW-1:0]     w_cnt_inc;

    assign w_a_pulse = a_read | a_write;
    assign w_b_issue = (r_state == S_PEND) && !w_a_pulse;
    assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;

    // Bus strobes: A always takes the slot, B only in a slot A leaves free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data_write <= '0;
            r_a_rd       <= 1'b0;
            r_a_rdata    <= '0;
        end else begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_a_rd  <= 1'b0;
            if (w_a_pulse) begin
                r_addr <= a_addr;
                if (a_write) begin
                    r_write      <= 1'b1;
                    r_data_write <= a_wdata;
                end else begin
                    r_read <= 1'b1;
                    r_a_rd <= 1'b1;
                end
            end else if (w_b_issue) begin
                r_addr <= r_b_addr;
                if (r_b_we) begin
                    r_write      <= 1'b1;
                    r_data_write <= r_b_wdata;
                end else begin
                    r_read <= 1'b1;
                end
            end
            if (r_a_rd) begin
                r_a_rdata <= data_read;
            end
        end
    end

    // B request FSM with saturating deferral counter and registered handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_b_we      <= 1'b0;
            r_b_addr    <= '0;
            r_b_wdata   <= '0;
            r_b_busy    <= 1'b0;
            r_b_ack     <= 1'b0;
            r_b_timeout <= 1'b0;
            r_b_rdata   <= '0;
        end else begin
            r_b_ack     <= 1'b0;
            r_b_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ABORT: begin
                    if (b_req) begin
                        r_b_we    <= b_we;
                        r_b_addr  <= b_addr;
                        r_b_wdata <= b_wdata;
                        r_b_busy  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_PEND;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PEND: begin
                    if (w_a_pulse) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_MAX) begin
                            r_b_busy    <= 1'b0;
                            r_b_timeout <= 1'b1;
                            r_state     <= S_ABORT;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!r_b_we) begin
                        r_b_rdata <= data_read;
                    end
                    r_b_busy <= 1'b0;
                    r_b_ack  <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign read       = r_read;
    assign write      = r_write;
    assign addr       = r_addr;
    assign data_write = r_data_write;
    assign a_rdata    = r_a_rdata;
    assign b_busy     = r_b_busy;
    assign b_ack      = r_b_ack;
    assign b_rdata    = r_b_rdata;
    assign b_timeout  = r_b_timeout;

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Scoreboard bench for regs_bus_arbiter with a small register-file model.
module tb_regs_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_read = 1'b0, a_write = 1'b0;
    logic [5:0] a_addr = '0;
    logic [7:0] a_wdata = '0, a_rdata;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [5:0] b_addr = '0;
    logic [7:0] b_wdata = '0, b_rdata;
    logic       b_busy, b_ack, b_timeout;
    logic       read, write;
    logic [5:0] addr;
    logic [7:0] data_write, data_read;

    regs_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_DEFER(15)) dut (
        .clk(clk), .rst(rst),
        .a_read(a_read), .a_write(a_write), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_busy(b_busy), .b_ack(b_ack),
        .b_rdata(b_rdata), .b_timeout(b_timeout),
        .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    assign data_read = mem[addr];
    always @(posedge clk) if (write) mem[addr] <= data_write;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic we; logic [5:0] ad; logic [7:0] d; } bus_t;
    typedef struct { int c; logic chk; logic [7:0] d; } dat_t;
    bus_t bq[$];
    dat_t aq[$];
    dat_t kq[$];
    int   tq[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bus_t e;
        dat_t k;
        int   t;
        if (read && write) check("rw_excl", 1, 0);
        if (read || write) begin
            if (bq.size() == 0) check("bus_unexp", {write, addr}, 0);
            else begin
                e = bq.pop_front();
                check("bus_cyc", cyc, e.c);
                check("bus_we", write, e.we);
                check("bus_addr", addr, e.ad);
                if (e.we) check("bus_wdata", data_write, e.d);
            end
        end
        if (aq.size() > 0 && aq[0].c == cyc) begin
            k = aq.pop_front();
            check("a_rdata", a_rdata, k.d);
        end
        if (b_ack) begin
            if (kq.size() == 0) check("ack_unexp", 1, 0);
            else begin
                k = kq.pop_front();
                check("ack_cyc", cyc, k.c);
                check("ack_busy", b_busy, 0);
                if (k.chk) check("b_rdata", b_rdata, k.d);
            end
        end
        if (b_timeout) begin
            if (tq.size() == 0) check("to_unexp", 1, 0);
            else begin
                t = tq.pop_front();
                check("to_cyc", cyc, t);
                check("to_busy", b_busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        a_read = 1'b0; a_write = 1'b0; b_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic a_wr(input logic [5:0] ad, input logic [7:0] d);
        a_write = 1'b1; a_addr = ad; a_wdata = d;
        bq.push_back('{cyc + 1, 1'b1, ad, d});
    endtask

    task automatic a_rd(input logic [5:0] ad, input logic [7:0] exp);
        a_read = 1'b1; a_addr = ad;
        bq.push_back('{cyc + 1, 1'b0, ad, 8'h00});
        aq.push_back('{cyc + 2, 1'b1, exp});
    endtask

    task automatic b_go(input logic we, input logic [5:0] ad,
                        input logic [7:0] d);
        b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = d;
    endtask

    task automatic drained(input string tag);
        check({tag, "_bq"}, bq.size(), 0);
        check({tag, "_aq"}, aq.size(), 0);
        check({tag, "_kq"}, kq.size(), 0);
        check({tag, "_tq"}, tq.size(), 0);
    endtask

    function automatic logic [63:0] outs();
        return {read, write, addr, data_write, a_rdata,
                b_busy, b_ack, b_rdata, b_timeout};
    endfunction

    int k;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        mem[6'h10] = 8'h3C;
        mem[6'h02] = 8'h11;

        idle(2);
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        idle(2);

        // A write, one cycle latency
        a_wr(6'h05, 8'hA5);
        tick();
        idle(3);
        drained("t2");

        // B read, idle A
        k = cyc;
        b_go(1'b0, 6'h10, 8'h00);
        bq.push_back('{k + 2, 1'b0, 6'h10, 8'h00});
        kq.push_back('{k + 3, 1'b1, 8'h3C});
        tick();
        check("busy_pend", b_busy, 1);
        idle(5);
        check("b_rdata_hold", b_rdata, 8'h3C);
        drained("t3");

        // B write deferred by three A pulses
        k = cyc;
        b_go(1'b1, 6'h30, 8'h44);
        tick();
        for (int i = 0; i < 3; i++) begin
            a_wr(6'(6'h20 + i), 8'(i + 1));
            tick();
        end
        check("busy_defer", b_busy, 1);
        bq.push_back('{k + 5, 1'b1, 6'h30, 8'h44});
        kq.push_back('{k + 6, 1'b0, 8'h00});
        idle(6);
        drained("t4");

        // MAX_DEFER-1 deferrals still issue
        k = cyc;
        b_go(1'b0, 6'h10, 8'h00);
        tick();
        for (int i = 0; i < 14; i++) begin
            a_wr(6'(6'h20 + (i % 8)), 8'(i + 8'h40));
            tick();
        end
        bq.push_back('{k + 16, 1'b0, 6'h10, 8'h00});
        kq.push_back('{k + 17, 1'b1, 8'h3C});
        idle(6);
        drained("t4b");

        // MAX_DEFER deferrals abort
        k = cyc;
        b_go(1'b1, 6'h31, 8'h55);
        tick();
        for (int i = 0; i < 15; i++) begin
            a_wr(6'(6'h20 + (i % 8)), 8'(i + 8'h60));
            if (i == 14) tq.push_back(k + 16);
            tick();
        end
        check("busy_abort", b_busy, 0);
        idle(6);
        check("no_b_write", mem[6'h31], 8'h31);
        drained("t5");

        // A read and B write to the same address in the same cycle
        k = cyc;
        a_rd(6'h02, 8'h11);
        b_go(1'b1, 6'h02, 8'h77);
        bq.push_back('{k + 2, 1'b1, 6'h02, 8'h77});
        kq.push_back('{k + 3, 1'b0, 8'h00});
        tick();
        idle(4);
        a_rd(6'h02, 8'h77);
        tick();
        idle(3);
        drained("t6");

        // reset held 3 cycles while B is pending
        b_go(1'b0, 6'h10, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        check("rst_outs0", outs(), 0);
        tick();
        check("rst_outs1", outs(), 0);
        tick();
        check("rst_outs2", outs(), 0);
        rst = 1'b0;
        idle(8);
        check("post_rst_busy", b_busy, 0);
        drained("t1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
